// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding ICache request FSM feeding a small in-order fetch buffer.
// Optional macro FETCH_JAL_PREDICT_EN redirects fetch to the target of a JAL as it is buffered.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       BUF_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clear_in,
  input  logic [ADDR_W-1:0]            redirect_pc_in,
  output logic                         icache_req_out,
  output logic [ADDR_W-1:0]            icache_addr_out,
  input  logic                         icache_valid_in,
  input  logic [31:0]                  icache_inst_in,
  input  logic                         iq_full_in,
  output logic                         inst_valid_out,
  output logic [31:0]                  inst_out,
  output logic [ADDR_W-1:0]            pc_out,
  output logic [$clog2(BUF_DEPTH):0]   buf_count_out
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_inst_q, out_inst_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  next_pc;

  logic [31:0]        inst_mem [BUF_DEPTH];
  logic [ADDR_W-1:0]  pc_mem   [BUF_DEPTH];

`ifdef FETCH_JAL_PREDICT_EN
  logic [20:0] j_imm;
  assign j_imm   = {icache_inst_in[31], icache_inst_in[19:12], icache_inst_in[20],
                    icache_inst_in[30:21], 1'b0};
  assign next_pc = (icache_inst_in[6:0] == 7'b1101111)
                 ? fetch_pc_q + ADDR_W'($signed(j_imm))
                 : fetch_pc_q + ADDR_W'(4);
`else
  assign next_pc = fetch_pc_q + ADDR_W'(4);
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (clear_in) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      fetch_pc_d  = redirect_pc_in;
      // A response landing in the same cycle as the clear retires the outstanding request.
      state_d     = (state_q != S_IDLE && !icache_valid_in) ? S_DROP : S_IDLE;
    end else if (rdy_in) begin
      pop         = (count_q != '0) && !iq_full_in;
      out_valid_d = pop;
      if (pop) begin
        out_inst_d = inst_mem[head_q];
        out_pc_d   = pc_mem[head_q];
        head_d     = head_q + PTR_W'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          // No push can happen while idle, so a free slot now is still free at the response.
          if (count_q < CNT_W'(BUF_DEPTH)) begin
            req_addr_d = fetch_pc_q;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (icache_valid_in) begin
            push       = 1'b1;
            tail_d     = tail_q + PTR_W'(1);
            fetch_pc_d = next_pc;
            state_d    = S_IDLE;
          end
        end
        S_DROP: begin
          if (icache_valid_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // NOTE: buffer storage is not reset; an entry is only read after being written.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail_q] <= icache_inst_in;
      pc_mem[tail_q]   <= fetch_pc_q;
    end
  end

  assign icache_req_out  = (state_q == S_WAIT);
  assign icache_addr_out = req_addr_q;
  assign inst_valid_out  = out_valid_q;
  assign inst_out        = out_inst_q;
  assign pc_out          = out_pc_q;
  assign buf_count_out   = count_q;

endmodule
